// File: rtl/ram_cmd_ctrl.sv
// ram_cmd_ctrl: in-order command sequencer in front of a single-port ram.
// Commands are buffered in a small FIFO, issued one at a time as a single
// cycle ram_en pulse, and read data is returned on a held response channel.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a FIFO head that may issue; pops it and drives ram_en
// ISSUE  | ram samples the command this cycle; ram_en drops
// CAPT   | read data is on ram_data_rd; latch it into the response regs
module ram_cmd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_wr_rdn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_wr,
  input  logic [DATA_WIDTH-1:0] ram_data_rd,
  output logic                  busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic                  fifo_wr_q   [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  head_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  // FSM and registered outputs
  state_t                state_q, state_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_wr_rdn_q, ram_wr_rdn_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_wr_q, ram_data_wr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;

  assign head_wr   = fifo_wr_q[rd_ptr_q];
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // Capture accepted commands into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q]   <= cmd_wr;
      fifo_addr_q[wr_ptr_q] <= cmd_addr;
      fifo_data_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at CMD_DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer registers; reset drops any pending commands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next-state and output decode. A read at the head waits while an earlier
  // response is still unaccepted, which also holds back everything behind it.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    ram_en_d      = 1'b0;
    ram_wr_rdn_d  = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_wr_d = ram_data_wr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_rdata_d   = rsp_rdata_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && (head_wr || !rsp_valid_q)) begin
          pop          = 1'b1;
          ram_en_d     = 1'b1;
          ram_wr_rdn_d = head_wr;
          ram_addr_d   = head_addr;
          if (head_wr) begin
            ram_data_wr_d = head_data;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // ram_wr_rdn_q still describes the command the ram is sampling now
        state_d = ram_wr_rdn_q ? S_IDLE : S_CAPT;
      end
      S_CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = ram_addr_q;
        rsp_rdata_d = ram_data_rd;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, ram drive and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      ram_en_q      <= 1'b0;
      ram_wr_rdn_q  <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_wr_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      ram_en_q      <= ram_en_d;
      ram_wr_rdn_q  <= ram_wr_rdn_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_wr_q <= ram_data_wr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_wr_rdn  = ram_wr_rdn_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_wr = ram_data_wr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign busy        = !fifo_empty || (state_q != S_IDLE);

endmodule
